// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback requesters.
// Grant is combinational (0 cycles); the granted write reaches the register file one cycle later.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 64,
    parameter int CNTW = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [5*NREQ-1:0]         req_rd,
    input  logic [XLEN*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      RegWrite,
    output logic [4:0]                WriteReg,
    output logic [XLEN-1:0]           WriteData,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      wb_stall,
    output logic [CNTW-1:0]           stall_cnt
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt;
    logic [IDW-1:0]  idx;
    logic [IDW-1:0]  next_ptr;
    logic [IDW:0]    sum;
    logic            found;
    logic [4:0]      rd_arr   [NREQ];
    logic [XLEN-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rd_arr[i]   = req_rd[5*i +: 5];
        assign data_arr[i] = req_data[XLEN*i +: XLEN];
    end

    // Search starts at rr_ptr and wraps modulo NREQ; first valid requester wins.
    always_comb begin
        req_ready = '0;
        gnt       = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found          = 1'b1;
                gnt            = idx;
                req_ready[idx] = 1'b1;
            end
        end
    end

    assign wb_stall = |(req_valid & ~req_ready);
    assign next_ptr = (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            grant_id  <= '0;
            stall_cnt <= '0;
        end else begin
            // x0 writes still complete the handshake but never pulse the write enable.
            RegWrite <= found && (rd_arr[gnt] != 5'd0);
            if (found) begin
                rr_ptr    <= next_ptr;
                grant_id  <= gnt;
                WriteReg  <= rd_arr[gnt];
                WriteData <= data_arr[gnt];
            end
            if (wb_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin, x0, same rd, saturation.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int XLEN = 64;
    localparam int CNTW = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_rd;
    logic [XLEN*NREQ-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 RegWrite;
    logic [4:0]           WriteReg;
    logic [XLEN-1:0]      WriteData;
    logic [1:0]           grant_id;
    logic                 wb_stall;
    logic [CNTW-1:0]      stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [XLEN-1:0] rf [32];

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .grant_id(grant_id), .wb_stall(wb_stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Register-file model: records every enabled write, including any to x0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) rf[r] <= '0;
        end else if (RegWrite) begin
            rf[WriteReg] <= WriteData;
        end
    end

    task automatic set_req(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
        req_rd[5*i +: 5]       = rd;
        req_data[XLEN*i +: XLEN] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if ({RegWrite, WriteReg, WriteData, grant_id, stall_cnt} !== '0) begin
            tests_failed++; $display("FAIL reset_init: got RegWrite=%0b WriteReg=%0d WriteData=%0h grant_id=%0d stall_cnt=%0d, expected all 0", RegWrite, WriteReg, WriteData, grant_id, stall_cnt);
        end
        @(negedge clk);
        set_req(0, 5'd3, 64'h33); set_req(1, 5'd4, 64'h44);
        req_valid = 3'b011;
        #1;
        tests_run++;
        if (req_ready !== 3'b001 || wb_stall !== 1'b1) begin
            tests_failed++; $display("FAIL reset_first_grant: got ready=%b stall=%b, expected 001/1", req_ready, wb_stall);
        end
        @(negedge clk);
        tests_run++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd3 || stall_cnt !== 4'd1 || req_ready !== 3'b010) begin
            tests_failed++; $display("FAIL reset_prewrite: got RegWrite=%b WriteReg=%0d stall_cnt=%0d ready=%b, expected 1/3/1/010", RegWrite, WriteReg, stall_cnt, req_ready);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({RegWrite, WriteReg, WriteData, grant_id, stall_cnt} !== '0) begin
            tests_failed++; $display("FAIL reset_async: got RegWrite=%0b WriteReg=%0d WriteData=%0h grant_id=%0d stall_cnt=%0d, expected all 0", RegWrite, WriteReg, WriteData, grant_id, stall_cnt);
        end
        tests_run++;
        if (req_ready !== 3'b001) begin
            tests_failed++; $display("FAIL reset_ptr_zero: got ready=%b expected 001", req_ready);
        end
        req_valid = 3'b111;
        @(negedge clk);
        tests_run++;
        if (stall_cnt !== 4'd0 || RegWrite !== 1'b0) begin
            tests_failed++; $display("FAIL reset_hold: got stall_cnt=%0d RegWrite=%b expected 0/0", stall_cnt, RegWrite);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 3'b001) begin
            tests_failed++; $display("FAIL reset_release: got ready=%b expected 001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_write();
        do_reset();
        @(negedge clk);
        set_req(1, 5'd5, 64'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        tests_run++;
        if (req_ready !== 3'b010 || wb_stall !== 1'b0) begin
            tests_failed++; $display("FAIL single_grant: got ready=%b stall=%b expected 010/0", req_ready, wb_stall);
        end
        @(negedge clk);
        tests_run++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 64'hDEAD_BEEF || grant_id !== 2'd1) begin
            tests_failed++; $display("FAIL single_write: got %b/%0d/%0h/%0d expected 1/5/deadbeef/1", RegWrite, WriteReg, WriteData, grant_id);
        end
        req_valid = '0;
        @(negedge clk);
        tests_run++;
        if (RegWrite !== 1'b0 || WriteReg !== 5'd5 || WriteData !== 64'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL single_pulse: got RegWrite=%b WriteReg=%0d WriteData=%0h expected 0/5/deadbeef", RegWrite, WriteReg, WriteData);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ready;
        do_reset();
        @(negedge clk);
        set_req(0, 5'd1, 64'h100); set_req(1, 5'd2, 64'h200); set_req(2, 5'd3, 64'h300);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_ready = 3'b001 << (k % 3);
            tests_run++;
            if (req_ready !== exp_ready) begin
                tests_failed++; $display("FAIL rr_grant_%0d: got ready=%b expected %b", k, req_ready, exp_ready);
            end
            if (k > 0) begin
                tests_run++;
                if (RegWrite !== 1'b1 || grant_id !== 2'((k-1) % 3) || WriteReg !== 5'(((k-1) % 3) + 1)) begin
                    tests_failed++; $display("FAIL rr_write_%0d: got RegWrite=%b grant_id=%0d WriteReg=%0d expected 1/%0d/%0d", k, RegWrite, grant_id, WriteReg, (k-1) % 3, ((k-1) % 3) + 1);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        tests_run++;
        if (RegWrite !== 1'b1 || grant_id !== 2'd2 || WriteData !== 64'h300 || stall_cnt !== 4'd6) begin
            tests_failed++; $display("FAIL rr_last: got RegWrite=%b grant_id=%0d WriteData=%0h stall_cnt=%0d expected 1/2/300/6", RegWrite, grant_id, WriteData, stall_cnt);
        end
        @(negedge clk);
        tests_run++;
        if (RegWrite !== 1'b0 || stall_cnt !== 4'd6) begin
            tests_failed++; $display("FAIL rr_idle: got RegWrite=%b stall_cnt=%0d expected 0/6", RegWrite, stall_cnt);
        end
    endtask

    task automatic test_x0_drop();
        do_reset();
        @(negedge clk);
        set_req(0, 5'd0, 64'd7);
        req_valid = 3'b001;
        #1;
        tests_run++;
        if (req_ready !== 3'b001) begin
            tests_failed++; $display("FAIL x0_grant: got ready=%b expected 001", req_ready);
        end
        @(negedge clk);
        tests_run++;
        if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== 64'd7) begin
            tests_failed++; $display("FAIL x0_write: got RegWrite=%b WriteReg=%0d WriteData=%0h expected 0/0/7", RegWrite, WriteReg, WriteData);
        end
        set_req(0, 5'd1, 64'h11); set_req(1, 5'd2, 64'h22); set_req(2, 5'd3, 64'h33);
        req_valid = 3'b111;
        #1;
        tests_run++;
        if (req_ready !== 3'b010) begin
            tests_failed++; $display("FAIL x0_ptr_advance: got ready=%b expected 010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        tests_run++;
        if (rf[0] !== 64'd0 || grant_id !== 2'd1) begin
            tests_failed++; $display("FAIL x0_regfile: got x0=%0h grant_id=%0d expected 0/1", rf[0], grant_id);
        end
    endtask

    task automatic test_same_dest();
        do_reset();
        @(negedge clk);
        set_req(0, 5'd10, 64'd1); set_req(2, 5'd10, 64'd2);
        req_valid = 3'b101;
        #1;
        tests_run++;
        if (req_ready !== 3'b001) begin
            tests_failed++; $display("FAIL same_first_grant: got ready=%b expected 001", req_ready);
        end
        @(negedge clk);
        req_valid = 3'b100;
        #1;
        tests_run++;
        if (RegWrite !== 1'b1 || WriteData !== 64'd1 || req_ready !== 3'b100) begin
            tests_failed++; $display("FAIL same_first_write: got RegWrite=%b WriteData=%0h ready=%b expected 1/1/100", RegWrite, WriteData, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        tests_run++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd10 || WriteData !== 64'd2 || stall_cnt !== 4'd1) begin
            tests_failed++; $display("FAIL same_second_write: got %b/%0d/%0h stall_cnt=%0d expected 1/10/2/1", RegWrite, WriteReg, WriteData, stall_cnt);
        end
        @(negedge clk);
        tests_run++;
        if (rf[10] !== 64'd2) begin
            tests_failed++; $display("FAIL same_regfile_x10: got %0h expected 2", rf[10]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        set_req(0, 5'd1, 64'hA); set_req(1, 5'd2, 64'hB);
        req_valid = 3'b011;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 10 || c == 15 || c == 20) begin
                tests_run++;
                if (stall_cnt !== 4'(c > 15 ? 15 : c)) begin
                    tests_failed++; $display("FAIL sat_cycle_%0d: got stall_cnt=%0d expected %0d", c, stall_cnt, (c > 15 ? 15 : c));
                end
            end
        end
        req_valid = '0;
        @(negedge clk);
        tests_run++;
        if (stall_cnt !== 4'd15) begin
            tests_failed++; $display("FAIL sat_hold: got stall_cnt=%0d expected 15", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_x0_drop();
        test_same_dest();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port (RegWrite/WriteReg/WriteData) between several writeback requesters, such as the ALU, load unit and multiply/divide unit. Grants are round-robin with valid/ready handshakes. The granted write is registered and driven to the register file one cycle after the handshake, and an x0 write is suppressed. The block sits between the execute/memory stages and register_file, and it reports writeback back-pressure through a stall flag and a saturating stall-cycle counter.

## Interface
- NREQ, 3, number of writeback requesters (2..8); requester 0 is the highest-priority index after reset
- XLEN, 64, data width
- CNTW, 16, stall counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i holds a pending write
- req_rd  in  5*NREQ  destination register of requester i, at bits [5i+4:5i]
- req_data  in  XLEN*NREQ  write data of requester i, at bits [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  NREQ  one-hot (or zero) grant; a transfer occurs when req_valid[i] && req_ready[i]
- RegWrite  out  1  registered write enable to the register file
- WriteReg  out  5  registered destination register
- WriteData  out  XLEN  registered write data
- grant_id  out  $clog2(NREQ)  index of the most recent transfer (registered)
- wb_stall  out  1  combinational; high when any valid requester is not granted this cycle
- stall_cnt  out  CNTW  number of cycles wb_stall was high; saturates

## Operation
- **Round-robin pointer.** rr_ptr ranges over 0..NREQ-1.
  - The grant goes to the first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, … and wrapping modulo NREQ.
  - req_ready is combinational from req_valid and rr_ptr; at most one bit is set.
  - With no valid requester, req_ready is all zero.
- **Transfer.** On a transfer from requester g:
  - rr_ptr <= (g+1) mod NREQ.
  - grant_id <= g.
  - WriteReg <= req_rd[g] and WriteData <= req_data[g].
  - RegWrite <= (req_rd[g] != 0).
- **Write to x0.** A request with rd = 0 completes its handshake and advances the pointer. RegWrite stays 0 for that cycle, while WriteReg and WriteData still load.
- **No transfer.** RegWrite <= 0. WriteReg, WriteData, grant_id and rr_ptr hold their values.
- **Requester protocol.** Once valid is raised, the requester holds valid, rd and data stable until ready.
  - If a requester drops valid early, the arbiter simply re-evaluates each cycle; there is no error state.
- **Same destination.** When two requesters target the same rd, the file sees them in grant order, so the later grant wins.
- **Stall.** wb_stall = |(req_valid & ~req_ready).
  - stall_cnt increments on each clock edge where wb_stall is 1.
  - It saturates at 2^CNTW-1 and does not wrap.
- **No bypass.** Data reaches the register file one cycle after the handshake. Forwarding around this register is the pipeline's responsibility.

## Timing
- Grant latency is 0 cycles: req_ready is valid in the same cycle as req_valid when the requester is selected.
- Write latency is 1 cycle: RegWrite, WriteReg and WriteData update on the clock edge that ends the handshake cycle.
- RegWrite is a one-cycle pulse per accepted write. Back-to-back transfers give back-to-back pulses with one write per cycle, so throughput is one write per clock.
- Worst-case wait for a continuously valid requester is NREQ-1 cycles.
- **Reset (asynchronous, immediate).** RegWrite=0, WriteReg=0, WriteData=0, grant_id=0, rr_ptr=0, stall_cnt=0.
  - req_ready then follows req_valid with requester 0 first.
  - Reset asserted in the cycle after a handshake squashes that pending RegWrite pulse; the write is lost.
- With rst high, req_ready and wb_stall still evaluate combinationally from rr_ptr=0. No state updates while rst is high.

## Test plan
- **Reset values.** Assert rst mid-stream → RegWrite, WriteReg, WriteData, grant_id and stall_cnt read 0 immediately, with no clock edge needed. Release rst with all three requesters valid → req_ready=3'b001.
- **Single write.** Requester 1 valid with rd=5, data=64'hDEAD_BEEF → req_ready=3'b010 in the same cycle. Next cycle RegWrite=1, WriteReg=5, WriteData=64'hDEADBEEF, grant_id=1. The cycle after that, RegWrite=0.
- **Round-robin.** All three requesters held valid for 6 cycles, rd=1/2/3 → grants 0,1,2,0,1,2. RegWrite stays high for 6 consecutive cycles. stall_cnt=6, because two requesters wait every cycle.
- **x0 drop.** Requester 0 valid with rd=0, data=7 → handshake occurs, RegWrite stays 0, WriteReg=0, rr_ptr advances (next grant with all valid is 1), and register 0 still reads 0.
- **Same destination.** Requesters 0 and 2 both target rd=10 with data 1 and 2, starting from rr_ptr=0 → WriteData=1 then 2 on successive cycles. register_file x10 ends at 2.
- **Saturation.** CNTW=4, requesters 0 and 1 valid for 20 cycles → stall_cnt reaches 15 and holds at 15.
